conv_loop_addr_gen: RTL and testbench

CONV_LOOP_ADDR_GEN -- requirements
Module: conv_loop_addr_gen

---
 rtl/conv_loop_addr_gen_if.sv | 41 ++++
 rtl/conv_loop_addr_gen.sv | 217 +++++++++++++++++++++
 tb/tb_conv_loop_addr_gen.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_loop_addr_gen_if.sv
// ---------------------------------------------------------------------------
// conv_loop_addr_gen_if
// Purpose : bundles the control and tap-stream signals of conv_loop_addr_gen.
// Handshake: a tap is transferred on a rising clk edge where out_valid and
//            out_ready are both 1. While out_valid=1 and out_ready=0, the
//            generator holds every tap field stable. out_valid never depends
//            combinationally on out_ready.
// Signals  : start, out_ready                     (consumer -> generator)
//            out_valid, pix_idx, wgt_idx, pad,
//            acc_clr, acc_last, out_idx, och_idx,
//            busy, done                           (generator -> consumer)
// Modports : master = generator side, slave = consumer/driver side.
// ---------------------------------------------------------------------------
interface conv_loop_addr_gen_if #(
    parameter int AW = 16
);
    logic          start;
    logic          out_ready;
    logic          out_valid;
    logic [AW-1:0] pix_idx;
    logic [AW-1:0] wgt_idx;
    logic          pad;
    logic          acc_clr;
    logic          acc_last;
    logic [AW-1:0] out_idx;
    logic [AW-1:0] och_idx;
    logic          busy;
    logic          done;

    modport master (
        input  start, out_ready,
        output out_valid, pix_idx, wgt_idx, pad, acc_clr, acc_last,
               out_idx, och_idx, busy, done
    );

    modport slave (
        output start, out_ready,
        input  out_valid, pix_idx, wgt_idx, pad, acc_clr, acc_last,
               out_idx, och_idx, busy, done
    );
endinterface

// File: rtl/conv_loop_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_loop_addr_gen
// Purpose : walks one convolution layer as the loop nest
//           och > h > w > ich > kh > kw and emits one tap per accepted
//           handshake: input pixel address (0 if padded), weight address,
//           output address, output channel and accumulate clear/last flags.
// Ports   : clk, xrst (async, active-low)
//           bus          conv_loop_addr_gen_if.master (start, out_ready in;
//                        out_valid, tap fields, busy, done out)
//           dbg_state_o  current FSM state (IDLE=0, RUN=1, DONE=2)
// Timing  : all outputs are flops. Tap fields are computed from the
//           next-state counters so the registered tap always matches the
//           counter registers; the first tap appears the cycle after start.
// ---------------------------------------------------------------------------
module conv_loop_addr_gen #(
    parameter int OCH   = 4,
    parameter int ICH   = 1,
    parameter int H     = 28,
    parameter int W     = 28,
    parameter int KSIZE = 3,
    parameter int AW    = 16
) (
    input  logic                        clk,
    input  logic                        xrst,
    conv_loop_addr_gen_if.master        bus,
    output logic [1:0]                  dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int HALF = KSIZE / 2;

    localparam logic [AW-1:0] OCH_MAX = AW'(OCH - 1);
    localparam logic [AW-1:0] H_MAX   = AW'(H - 1);
    localparam logic [AW-1:0] W_MAX   = AW'(W - 1);
    localparam logic [AW-1:0] ICH_MAX = AW'(ICH - 1);
    localparam logic [AW-1:0] K_MAX   = AW'(KSIZE - 1);
    localparam logic [AW-1:0] ONE     = AW'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] och_q, och_d, h_q, h_d, w_q, w_d;
    logic [AW-1:0] ich_q, ich_d, kh_q, kh_d, kw_q, kw_d;
    logic          valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic          load;

    logic [AW-1:0] pix_q, pix_d, wgt_q, wgt_d, oidx_q, oidx_d, ochi_q, ochi_d;
    logic          pad_q, pad_d, clr_q, clr_d, last_q, last_d;

    logic kw_max, kh_max, ich_max, w_max, h_max, och_max, all_max;

    assign kw_max  = (kw_q  == K_MAX);
    assign kh_max  = (kh_q  == K_MAX);
    assign ich_max = (ich_q == ICH_MAX);
    assign w_max   = (w_q   == W_MAX);
    assign h_max   = (h_q   == H_MAX);
    assign och_max = (och_q == OCH_MAX);
    assign all_max = kw_max & kh_max & ich_max & w_max & h_max & och_max;

    // FSM and counter nest. Counters only move on an accepted tap; the
    // carry chain ripples outward exactly like nested for-loops.
    always_comb begin
        state_d = state_q;
        och_d   = och_q;
        h_d     = h_q;
        w_d     = w_q;
        ich_d   = ich_q;
        kh_d    = kh_q;
        kw_d    = kw_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    och_d   = '0;
                    h_d     = '0;
                    w_d     = '0;
                    ich_d   = '0;
                    kh_d    = '0;
                    kw_d    = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.out_ready) begin
                    if (all_max) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        och_d   = '0;
                        h_d     = '0;
                        w_d     = '0;
                        ich_d   = '0;
                        kh_d    = '0;
                        kw_d    = '0;
                    end else begin
                        load = 1'b1;
                        kw_d = kw_q + ONE;
                        if (kw_max) begin
                            kw_d = '0;
                            kh_d = kh_q + ONE;
                            if (kh_max) begin
                                kh_d  = '0;
                                ich_d = ich_q + ONE;
                                if (ich_max) begin
                                    ich_d = '0;
                                    w_d   = w_q + ONE;
                                    if (w_max) begin
                                        w_d = '0;
                                        h_d = h_q + ONE;
                                        if (h_max) begin
                                            h_d   = '0;
                                            och_d = och_q + ONE;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Tap fields for the counter values about to be registered. Input row and
    // column are signed so kernel taps left of / above the map show as < 0.
    always_comb begin
        int ph;
        int pw;
        ph     = int'(h_d) + int'(kh_d) - HALF;
        pw     = int'(w_d) + int'(kw_d) - HALF;
        pad_d  = (ph < 0) || (ph >= H) || (pw < 0) || (pw >= W);
        pix_d  = pad_d ? '0 : AW'((int'(ich_d) * H + ph) * W + pw);
        wgt_d  = AW'(((int'(och_d) * ICH + int'(ich_d)) * KSIZE + int'(kh_d)) * KSIZE
                     + int'(kw_d));
        oidx_d = AW'((int'(och_d) * H + int'(h_d)) * W + int'(w_d));
        ochi_d = och_d;
        clr_d  = (ich_d == '0) && (kh_d == '0) && (kw_d == '0);
        last_d = (ich_d == ICH_MAX) && (kh_d == K_MAX) && (kw_d == K_MAX);
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= S_IDLE;
            och_q   <= '0;
            h_q     <= '0;
            w_q     <= '0;
            ich_q   <= '0;
            kh_q    <= '0;
            kw_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            och_q   <= och_d;
            h_q     <= h_d;
            w_q     <= w_d;
            ich_q   <= ich_d;
            kh_q    <= kh_d;
            kw_q    <= kw_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Tap registers only change when a new tap is presented, which is what
    // keeps them frozen through consumer stalls.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            pix_q  <= '0;
            wgt_q  <= '0;
            oidx_q <= '0;
            ochi_q <= '0;
            pad_q  <= 1'b0;
            clr_q  <= 1'b0;
            last_q <= 1'b0;
        end else if (load) begin
            pix_q  <= pix_d;
            wgt_q  <= wgt_d;
            oidx_q <= oidx_d;
            ochi_q <= ochi_d;
            pad_q  <= pad_d;
            clr_q  <= clr_d;
            last_q <= last_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.pix_idx   = pix_q;
    assign bus.wgt_idx   = wgt_q;
    assign bus.pad       = pad_q;
    assign bus.acc_clr   = clr_q;
    assign bus.acc_last  = last_q;
    assign bus.out_idx   = oidx_q;
    assign bus.och_idx   = ochi_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_conv_loop_addr_gen.sv
module tb_conv_loop_addr_gen;

  localparam int AW = 16;
  localparam int TW = 4 * AW + 3;

  typedef struct packed {
    logic [AW-1:0] pix;
    logic [AW-1:0] wgt;
    logic [AW-1:0] oidx;
    logic [AW-1:0] och;
    logic          pad;
    logic          clr;
    logic          last;
  } tap_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic xrst;
  logic [1:0] st_a, st_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_loop_addr_gen_if #(.AW(AW)) if_a ();
  conv_loop_addr_gen_if #(.AW(AW)) if_b ();

  conv_loop_addr_gen #(.OCH(2), .ICH(1), .H(4), .W(4), .KSIZE(3), .AW(AW)) dut_a (
    .clk(clk), .xrst(xrst), .bus(if_a), .dbg_state_o(st_a)
  );

  conv_loop_addr_gen #(.OCH(1), .ICH(1), .H(2), .W(2), .KSIZE(1), .AW(AW)) dut_b (
    .clk(clk), .xrst(xrst), .bus(if_b), .dbg_state_o(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [TW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: tap n decomposed by mixed-radix division, innermost digit kw.
  function automatic tap_t model_tap(int n_och, int n_ich, int hh, int ww, int k, int n);
    tap_t t;
    int kw, kh, ich, w, h, och, ph, pw, r;
    r = n;
    kw = r % k;     r = r / k;
    kh = r % k;     r = r / k;
    ich = r % n_ich; r = r / n_ich;
    w = r % ww;     r = r / ww;
    h = r % hh;     r = r / hh;
    och = r;
    ph = h + kh - k / 2;
    pw = w + kw - k / 2;
    t.pad  = (ph < 0 || ph >= hh || pw < 0 || pw >= ww);
    t.pix  = t.pad ? '0 : AW'((ich * hh + ph) * ww + pw);
    t.wgt  = AW'(((och * n_ich + ich) * k + kh) * k + kw);
    t.oidx = AW'((och * hh + h) * ww + w);
    t.och  = AW'(och);
    t.clr  = (ich == 0 && kh == 0 && kw == 0);
    t.last = (ich == n_ich - 1 && kh == k - 1 && kw == k - 1);
    return t;
  endfunction

  function automatic int total_taps(bit sel);
    return sel ? 1 * 1 * 2 * 2 * 1 * 1 : 2 * 1 * 4 * 4 * 3 * 3;
  endfunction

  task automatic fill_exp(input bit sel);
    exp_q.delete();
    for (int n = 0; n < total_taps(sel); n++) begin
      if (sel) exp_q.push_back(model_tap(1, 1, 2, 2, 1, n));
      else     exp_q.push_back(model_tap(2, 1, 4, 4, 3, n));
    end
  endtask

  // ---------------- driver / monitor helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input bit sel, input logic v);
    if (sel) if_b.start = v;
    else     if_a.start = v;
  endtask

  task automatic drive_ready(input logic v);
    if_a.out_ready = v;
    if_b.out_ready = v;
  endtask

  function automatic tap_t get_tap(bit sel);
    tap_t t;
    if (sel) begin
      t.pix = if_b.pix_idx; t.wgt = if_b.wgt_idx; t.oidx = if_b.out_idx; t.och = if_b.och_idx;
      t.pad = if_b.pad; t.clr = if_b.acc_clr; t.last = if_b.acc_last;
    end else begin
      t.pix = if_a.pix_idx; t.wgt = if_a.wgt_idx; t.oidx = if_a.out_idx; t.och = if_a.och_idx;
      t.pad = if_a.pad; t.clr = if_a.acc_clr; t.last = if_a.acc_last;
    end
    return t;
  endfunction

  function automatic logic get_valid(bit sel);
    return sel ? if_b.out_valid : if_a.out_valid;
  endfunction

  function automatic logic get_busy(bit sel);
    return sel ? if_b.busy : if_a.busy;
  endfunction

  function automatic logic get_done(bit sel);
    return sel ? if_b.done : if_a.done;
  endfunction

  // One sweep. rnd: random out_ready; poke: pulse start mid-run;
  // reset_at: assert xrst right after that many accepted taps (-1 = never).
  task automatic run_sweep(input bit sel, input bit rnd, input bit poke, input int reset_at);
    int total, count, cycles, budget;
    tap_t prev;
    logic pv, pr;
    total = total_taps(sel);
    fill_exp(sel);
    count = 0;
    cycles = 0;
    budget = total * 4 + 64;
    drive_start(sel, 1'b1);
    step();
    drive_start(sel, 1'b0);
    check("first_valid", get_valid(sel), 1'b1);
    check("busy_run", get_busy(sel), 1'b1);
    while (count < total && cycles < budget) begin
      pr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_ready(pr);
      drive_start(sel, poke && count >= 50 && count <= 52);
      prev = get_tap(sel);
      pv = get_valid(sel);
      step();
      cycles++;
      if (pv && pr) begin
        check("tap", prev, exp_q.pop_front());
        count++;
        if (count < total) check("no_early_done", get_done(sel), 1'b0);
        if (count == reset_at) begin
          drive_start(sel, 1'b0);
          xrst = 1'b0;
          #1;
          check("rst_busy", get_busy(sel), 1'b0);
          check("rst_valid", get_valid(sel), 1'b0);
          check("rst_done", get_done(sel), 1'b0);
          check("rst_tap", get_tap(sel), '0);
          step();
          xrst = 1'b1;
          step();
          check("post_rst_idle_valid", get_valid(sel), 1'b0);
          check("post_rst_idle_busy", get_busy(sel), 1'b0);
          exp_q.delete();
          return;
        end
      end else begin
        check("stall_hold", {get_valid(sel), get_tap(sel)}, {1'b1, prev});
      end
    end
    drive_start(sel, 1'b0);
    check("tap_count", count, total);
    check("done_pulse", get_done(sel), 1'b1);
    check("done_valid_low", get_valid(sel), 1'b0);
    check("done_busy", get_busy(sel), 1'b1);
    step();
    check("done_clear", get_done(sel), 1'b0);
    check("idle_busy", get_busy(sel), 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    xrst = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    drive_ready(1'b0);
    step();
    step();
    check("reset_valid_a", if_a.out_valid, 1'b0);
    check("reset_busy_a", if_a.busy, 1'b0);
    check("reset_done_a", if_a.done, 1'b0);
    check("reset_tap_a", get_tap(1'b0), '0);
    check("reset_valid_b", if_b.out_valid, 1'b0);
    xrst = 1'b1;
    drive_ready(1'b1);
    step();
    check("idle_no_start", if_a.out_valid, 1'b0);

    run_sweep(1'b0, 1'b0, 1'b0, -1);   // full-rate sweep
    run_sweep(1'b0, 1'b1, 1'b0, -1);   // back-to-back, random stalls
    run_sweep(1'b0, 1'b0, 1'b1, -1);   // start ignored while running
    run_sweep(1'b0, 1'b1, 1'b0, 100);  // reset mid-sweep
    run_sweep(1'b0, 1'b0, 1'b0, -1);   // restart after reset
    run_sweep(1'b1, 1'b0, 1'b0, -1);   // 1x1 kernel, 2x2 map
    run_sweep(1'b1, 1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
